// File: rtl/reg_pipe_elastic.sv
// reg_pipe_elastic
//   DEPTH-stage register pipeline with valid/ready flow control.
//   Empty stages always accept data, so bubbles collapse while the output
//   is stalled. The ready chain is purely combinational, and out_valid and
//   out_data come straight from the last stage's registers.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; overrides everything
//   flush      synchronous clear of the pipeline contents; forces in_ready low
//   in_valid   upstream presents a word
//   in_data    upstream word (WIDTH bits)
//   in_ready   the pipeline accepts in_data on this edge
//   out_valid  word available at the output (valid bit of the last stage)
//   out_data   data register of the last stage
//   out_ready  downstream accepts out_data on this edge
//   occupancy  number of valid stages, 0..DEPTH (registered)
module reg_pipe_elastic #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage 0 is the input side and stage DEPTH-1 is the output side.
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic [DEPTH-1:0] rdy;
  logic [OCC_W-1:0] occ;
  logic [OCC_W-1:0] occ_next;
  logic             in_fire;
  logic             out_fire;

  // Ready chain. A stage can load when it is empty, or when the stage ahead
  // of it loads on the same edge. The last stage looks at out_ready. The
  // chain runs from the output side back toward the input.
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = !v[i] || acc;
      rdy[i] = acc;
    end
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
  assign occupancy = occ;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // The occupancy counter is tracked incrementally. It stays equal to the
  // popcount of v because each word that enters or leaves the pipeline
  // changes exactly one of the two.
  always_comb begin
    occ_next = occ;
    case ({in_fire, out_fire})
      2'b10:   occ_next = occ + OCC_W'(1);
      2'b01:   occ_next = occ - OCC_W'(1);
      default: occ_next = occ;
    endcase
  end

  // Stage registers and the occupancy counter.
  // flush clears the pipeline the same way rst does. A word that leaves
  // through the output in the flush cycle has already been consumed
  // downstream, so no accounting is needed for it.
  // A loading stage copies data even when the incoming valid bit is 0.
  // Data in an invalid stage is don't-care, and skipping the data-enable
  // keeps the datapath simple.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v   <= '0;
      occ <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d[i] <= RESET_VAL;
      end
    end else begin
      if (rdy[0]) begin
        v[0] <= in_valid;
        d[0] <= in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v[i] <= v[i-1];
          d[i] <= d[i-1];
        end
      end
      occ <= occ_next;
    end
  end

endmodule

// File: tb/tb_reg_pipe_elastic.sv
// tb_reg_pipe_elastic
//   Directed plus randomized bench for reg_pipe_elastic (WIDTH=8, DEPTH=3).
//   The reference model keeps the words in flight as a queue, oldest first,
//   and stores each word's stage position. On each edge every word moves one
//   stage forward unless the slot ahead of it is still held by an older word
//   that does not move. A word moving past the last stage leaves the pipeline.
module tb_reg_pipe_elastic;

  localparam int         WIDTH     = 8;
  localparam int         DEPTH     = 3;
  localparam int         OCC_W     = $clog2(DEPTH + 1);
  localparam logic [7:0] RESET_VAL = 8'hC3;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [OCC_W-1:0] occupancy;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  int         mp[$];
  int         np[$];
  int         lim;

  reg_pipe_elastic #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_VAL(RESET_VAL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Work out the stage position of each word after the next edge.
  // lim is the lowest slot still taken once the edge has happened, which
  // tells us whether stage 0 is free for a new word.
  task automatic compute_next(input bit oready);
    int p;
    np  = {};
    lim = oready ? DEPTH + 1 : DEPTH;
    for (int k = 0; k < mp.size(); k++) begin
      p = mp[k];
      if (p + 1 < lim) p = p + 1;
      np.push_back(p);
      lim = p;
    end
  endtask

  task automatic check_output();
    bit exp_ov;
    compute_next(out_ready);
    exp_ov = (mp.size() > 0) && (mp[0] == DEPTH - 1);
    check("in_ready", in_ready, (!flush && lim > 0));
    check("out_valid", out_valid, exp_ov);
    if (exp_ov) check("out_data", out_data, mq[0]);
    check("occupancy", occupancy, mq.size());
  endtask

  task automatic model_update();
    if (rst || flush) begin
      mq = {};
      mp = {};
    end else begin
      for (int k = 0; k < mp.size(); k++) mp[k] = np[k];
      if (mp.size() > 0 && mp[0] == DEPTH) begin
        void'(mp.pop_front());
        void'(mq.pop_front());
      end
      if (in_valid && lim > 0) begin
        mq.push_back(in_data);
        mp.push_back(0);
      end
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit f, input bit iv,
                                input logic [7:0] id, input bit ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #2;
    check_output();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq = {};
    mp = {};
    rst = 1'b0;

    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_out_data", out_data, RESET_VAL);

    // Stream three words with the output always ready.
    apply_stimulus(0, 0, 1, 8'h11, 1);
    apply_stimulus(0, 0, 1, 8'h22, 1);
    apply_stimulus(0, 0, 1, 8'h33, 1);
    check("stream_occ_peak", occupancy, 3);
    check("stream_first_out", out_data, 8'h11);
    repeat (4) apply_stimulus(0, 0, 0, 8'h00, 1);

    // Fill the pipeline while stalled. A4 is presented but must wait.
    apply_stimulus(0, 0, 1, 8'hA1, 0);
    apply_stimulus(0, 0, 1, 8'hA2, 0);
    apply_stimulus(0, 0, 1, 8'hA3, 0);
    apply_stimulus(0, 0, 1, 8'hA4, 0);
    check("full_hold_data", out_data, 8'hA1);
    check("full_occ", occupancy, 3);

    // Drain one word and accept A4 on the same edge.
    apply_stimulus(0, 0, 1, 8'hA4, 1);
    check("swap_occ", occupancy, 3);
    check("swap_next_data", out_data, 8'hA2);
    repeat (5) apply_stimulus(0, 0, 0, 8'h00, 1);

    // Bubble collapse with the output stalled.
    apply_stimulus(0, 0, 1, 8'h5A, 0);
    repeat (2) apply_stimulus(0, 0, 0, 8'h00, 0);
    apply_stimulus(0, 0, 1, 8'h5B, 0);
    check("bubble_occ", occupancy, 2);
    check("bubble_head", out_data, 8'h5A);
    check("bubble_in_ready", in_ready, 1);

    // Flush while a word is presented. That word must never appear.
    apply_stimulus(0, 1, 1, 8'hFF, 0);
    check("flush_occ", occupancy, 0);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_data", out_data, RESET_VAL);
    repeat (4) apply_stimulus(0, 0, 0, 8'h00, 1);

    // Reset in the middle of a full stream, then resume.
    for (int k = 0; k < 5; k++) apply_stimulus(0, 0, 1, 8'h40 + 8'(k), 1);
    apply_stimulus(1, 0, 1, 8'h77, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_out_data", out_data, RESET_VAL);
    apply_stimulus(0, 0, 1, 8'h81, 1);
    apply_stimulus(0, 0, 0, 8'h00, 1);
    apply_stimulus(0, 0, 0, 8'h00, 1);
    check("resume_first_word", out_data, 8'h81);
    check("resume_out_valid", out_valid, 1);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      apply_stimulus($urandom_range(99) == 0,
                     $urandom_range(29) == 0,
                     $urandom_range(3) != 0,
                     8'($urandom),
                     $urandom_range(9) < 6);
    end
    repeat (6) apply_stimulus(0, 0, 0, 8'h00, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
